// File: rtl/irq_sequencer.sv
// Interrupt sequencer: edge-detects peripheral sources, masks and prioritises them, and raises irq
// to the ID-stage decoder only at a pipeline-safe point. Optional timeout flag under IRQ_TIMEOUT_EN.
module irq_sequencer #(
    parameter int unsigned N_SRC   = 4,
    parameter int unsigned CAUSE_W = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SRC-1:0]   irq_src,
    input  logic               cfg_we,
    input  logic               cfg_sel,
    input  logic [N_SRC-1:0]   cfg_wdata,
    input  logic               pc_31,
    input  logic               pc_id_31,
    input  logic               stall,
    output logic               irq,
    output logic [CAUSE_W-1:0] irq_cause,
    output logic [N_SRC-1:0]   pending,
    output logic [N_SRC-1:0]   mask,
    output logic               irq_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        FIRE,
        SERVICE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [N_SRC-1:0]   src_q;
    logic [N_SRC-1:0]   edges;
    logic [N_SRC-1:0]   req;
    logic [N_SRC-1:0]   pend_clr;
    logic [N_SRC-1:0]   pending_nxt;
    logic [N_SRC-1:0]   mask_nxt;
    logic [CAUSE_W-1:0] winner;
    logic [CAUSE_W-1:0] cause_nxt;
    logic               irq_nxt;
    logic               svc_clr;
    logic               any_req;
    logic               safe;

    assign edges   = irq_src & ~src_q;
    assign req     = pending & mask;
    assign any_req = |req;
    assign safe    = ~pc_31 & ~pc_id_31 & ~stall;

    // Scan from the top index down so the lowest set bit is written last and wins.
    always_comb begin
        winner = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (req[N_SRC-1-i]) begin
                winner = CAUSE_W'(N_SRC-1-i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        irq_nxt   = irq;
        cause_nxt = irq_cause;
        svc_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (!any_req) begin
                    state_nxt = IDLE;
                end else if (safe) begin
                    irq_nxt   = 1'b1;
                    cause_nxt = winner;
                    state_nxt = FIRE;
                end
            end
            FIRE: begin
                if (pc_31) begin
                    irq_nxt   = 1'b0;
                    svc_clr   = 1'b1;
                    state_nxt = SERVICE;
                end
            end
            SERVICE: begin
                if (!pc_31 && !pc_id_31) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Clears are applied before new edges are OR-ed in, so a same-cycle set always survives.
    always_comb begin
        pend_clr = '0;
        if (cfg_we && cfg_sel) begin
            pend_clr = cfg_wdata;
        end
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (svc_clr && (irq_cause == CAUSE_W'(i))) begin
                pend_clr[i] = 1'b1;
            end
        end
        pending_nxt = (pending & ~pend_clr) | edges;
        mask_nxt    = (cfg_we && !cfg_sel) ? cfg_wdata : mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            src_q     <= '0;
            pending   <= '0;
            mask      <= '0;
            irq       <= 1'b0;
            irq_cause <= '0;
        end else begin
            state     <= state_nxt;
            src_q     <= irq_src;
            pending   <= pending_nxt;
            mask      <= mask_nxt;
            irq       <= irq_nxt;
            irq_cause <= cause_nxt;
        end
    end

`ifdef IRQ_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] arm_cnt;
    logic             cnt_hit;

    assign cnt_hit = (state == ARM) && (arm_cnt != TMO_LIM) && ((arm_cnt + 1'b1) == TMO_LIM);

    // Counter saturates at the limit so a long ARM wait cannot wrap it.
    always_ff @(posedge clk) begin
        if (reset) begin
            arm_cnt     <= '0;
            irq_timeout <= 1'b0;
        end else begin
            if (state == IDLE && state_nxt == ARM) begin
                arm_cnt <= '0;
            end else if (state == ARM && arm_cnt != TMO_LIM) begin
                arm_cnt <= arm_cnt + 1'b1;
            end
            if (cnt_hit) begin
                irq_timeout <= 1'b1;
            end else if (cfg_we && cfg_sel && cfg_wdata == '0) begin
                irq_timeout <= 1'b0;
            end
        end
    end
`else
    assign irq_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_irq_sequencer.sv
// Scoreboard bench for irq_sequencer: stimulus queues expected irq assertions (cause and cycle),
// a negedge monitor pops and checks them; register state is checked directly by the stimulus.
module tb_irq_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_src;
    logic       cfg_we;
    logic       cfg_sel;
    logic [3:0] cfg_wdata;
    logic       pc_31;
    logic       pc_id_31;
    logic       stall;
    logic       irq;
    logic [1:0] irq_cause;
    logic [3:0] pending;
    logic [3:0] mask;
    logic       irq_timeout;

    irq_sequencer #(
        .N_SRC   (4),
        .CAUSE_W (2),
        .TIMEOUT (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .irq_src     (irq_src),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_wdata   (cfg_wdata),
        .pc_31       (pc_31),
        .pc_id_31    (pc_id_31),
        .stall       (stall),
        .irq         (irq),
        .irq_cause   (irq_cause),
        .pending     (pending),
        .mask        (mask),
        .irq_timeout (irq_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cause;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic        irq_prev = 1'b0;

`ifdef IRQ_TIMEOUT_EN
    localparam logic EXP_TMO = 1'b1;
`else
    localparam logic EXP_TMO = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int unsigned cause, input int unsigned delay);
        exp_t e;
        e.cause = cause;
        e.cyc   = cyc + delay;
        q.push_back(e);
    endtask

    task automatic cfg(input logic sel, input logic [3:0] d);
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
        cfg_sel   = 1'b0;
        cfg_wdata = '0;
    endtask

    task automatic service();
        pc_31 = 1'b1;
        tick();
        chk("irq_drop_on_entry", irq, 1'b0);
        pc_31 = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin
        if (irq && !irq_prev) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_irq: got irq=1 cause=%0d expected no request (cycle %0d)",
                         irq_cause, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("mon_irq_cause", irq_cause, mon_e.cause);
                chk("mon_irq_cycle", cyc, mon_e.cyc);
            end
        end
        irq_prev = irq;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; irq_src = '0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_wdata = '0;
        pc_31 = 1'b0; pc_id_31 = 1'b0; stall = 1'b0;
        tick(); tick();
        chk("rst_irq", irq, 1'b0);
        chk("rst_pending", pending, 4'b0000);
        chk("rst_mask", mask, 4'b0000);
        chk("rst_cause", irq_cause, 2'd0);
        chk("rst_timeout", irq_timeout, 1'b0);
        reset = 1'b0;
        tick();

        // Basic: single source, safe pipeline, latency of three edges.
        cfg(1'b0, 4'b0010);
        irq_src = 4'b0010;
        push(1, 3);
        tick();
        chk("basic_pending", pending, 4'b0010);
        chk("basic_irq_early", irq, 1'b0);
        tick(); tick();
        chk("basic_irq", irq, 1'b1);
        chk("basic_cause", irq_cause, 2'd1);
        service();
        chk("basic_pending_clr", pending, 4'b0000);
        irq_src = '0;
        tick();

        // Priority: src 0 and src 3 together.
        cfg(1'b0, 4'b1111);
        irq_src = 4'b1001;
        push(0, 3);
        tick(); tick(); tick();
        chk("prio_first_cause", irq_cause, 2'd0);
        chk("prio_pending", pending, 4'b1001);
        pc_31 = 1'b1;
        tick();
        chk("prio_pending_after", pending, 4'b1000);
        pc_31 = 1'b0;
        push(3, 3);
        tick(); tick(); tick();
        chk("prio_second_irq", irq, 1'b1);
        chk("prio_second_cause", irq_cause, 2'd3);
        service();
        irq_src = '0;
        tick();

        // Unsafe hold by stall.
        stall = 1'b1;
        irq_src = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_hold", irq, 1'b0);
        end
        stall = 1'b0;
        push(2, 1);
        tick();
        chk("stall_release", irq, 1'b1);
        chk("stall_cause", irq_cause, 2'd2);
        service();
        irq_src = '0;
        tick();

        // Unsafe hold by kernel instruction in ID.
        pc_id_31 = 1'b1;
        irq_src = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("pcid_hold", irq, 1'b0);
        end
        pc_id_31 = 1'b0;
        push(3, 1);
        tick();
        chk("pcid_release", irq, 1'b1);
        chk("pcid_cause", irq_cause, 2'd3);
        service();
        irq_src = '0;
        tick();

        // Masked source, then clear colliding with a new edge, then unmask.
        cfg(1'b0, 4'b0000);
        irq_src = 4'b0100;
        tick();
        chk("masked_pending", pending, 4'b0100);
        tick(); tick();
        chk("masked_no_irq", irq, 1'b0);
        irq_src = '0;
        tick();
        irq_src = 4'b0100;
        cfg(1'b1, 4'b0100);
        chk("set_beats_clear", pending, 4'b0100);
        push(2, 3);
        cfg(1'b0, 4'b0100);
        chk("mask_loaded", mask, 4'b0100);
        tick(); tick();
        chk("unmask_irq", irq, 1'b1);
        chk("unmask_cause", irq_cause, 2'd2);
        cfg(1'b0, 4'b0000);
        chk("fire_not_aborted", irq, 1'b1);
        chk("fire_cause_frozen", irq_cause, 2'd2);
        service();
        chk("masked_pending_clr", pending, 4'b0000);
        irq_src = '0;
        tick();

        // Mask removed while waiting in ARM drops back to IDLE; then software clear.
        cfg(1'b0, 4'b1111);
        stall = 1'b1;
        irq_src = 4'b0010;
        tick(); tick(); tick();
        cfg(1'b0, 4'b0000);
        tick();
        stall = 1'b0;
        tick(); tick(); tick();
        chk("disarm_no_irq", irq, 1'b0);
        chk("disarm_pending", pending, 4'b0010);
        cfg(1'b1, 4'b0010);
        chk("sw_clear", pending, 4'b0000);
        irq_src = '0;
        tick();

        // ARM timeout (flag only exists with IRQ_TIMEOUT_EN).
        cfg(1'b0, 4'b0001);
        stall = 1'b1;
        irq_src = 4'b0001;
        for (int i = 0; i < 6; i++) tick();
        chk("tmo_before", irq_timeout, 1'b0);
        tick();
        chk("tmo_set", irq_timeout, EXP_TMO);
        tick();
        stall = 1'b0;
        push(0, 1);
        tick();
        chk("tmo_irq", irq, 1'b1);
        chk("tmo_sticky", irq_timeout, EXP_TMO);
        service();
        chk("tmo_sticky_svc", irq_timeout, EXP_TMO);
        cfg(1'b1, 4'b0000);
        chk("tmo_cleared", irq_timeout, 1'b0);
        irq_src = '0;
        tick();

        // Reset while FIRE is active.
        irq_src = 4'b0001;
        push(0, 3);
        tick(); tick(); tick();
        chk("prereset_irq", irq, 1'b1);
        reset = 1'b1;
        tick();
        chk("midrst_irq", irq, 1'b0);
        chk("midrst_pending", pending, 4'b0000);
        chk("midrst_mask", mask, 4'b0000);
        chk("midrst_cause", irq_cause, 2'd0);
        reset = 1'b0;
        irq_src = '0;
        for (int i = 0; i < 5; i++) tick();
        chk("final_irq", irq, 1'b0);
        chk("queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
